nios_system_timer_sequencer: RTL and testbench



---
 rtl/nios_system_timer_sequencer_if.sv | 23 ++
 rtl/nios_system_timer_sequencer.sv | 140 ++++++++++++++
 tb/tb_nios_system_timer_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_timer_sequencer_if.sv
// Avalon-MM write-only link between the sequencer and the system interval timer,
// with the timer interrupt returned on the same bundle.
`default_nettype none

interface nios_system_timer_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output irq
  );
endinterface

`default_nettype wire

// File: rtl/nios_system_timer_sequencer.sv
// Programs the system interval timer over Avalon-MM, acknowledges its timeouts
// and exports a tick pulse and tick counter. Rev 1.0
`default_nettype none

module nios_system_timer_sequencer #(
  parameter int          TICK_W         = 16,
  parameter bit          AUTO_START     = 1'b0,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50000
) (
  input  wire                              clk,
  input  wire                              reset,
  input  wire                              cmd_start,
  input  wire                              cmd_stop,
  input  wire  [31:0]                      cmd_period,
  input  wire                              cmd_continuous,
  nios_system_timer_sequencer_if.master    tmr,
  output logic                             busy,
  output logic                             tick,
  output logic [TICK_W-1:0]                tick_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_PL   = 3'd1;
  localparam logic [2:0] WR_PH   = 3'd2;
  localparam logic [2:0] WR_CTRL = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;
  localparam logic [2:0] ACK     = 3'd5;
  localparam logic [2:0] WR_STOP = 3'd6;

  localparam logic [2:0]  RESET_STATE = AUTO_START ? WR_PL : IDLE;
  localparam logic [31:0] RESET_PLEN  = !AUTO_START ? 32'd0 :
                                        (DEFAULT_PERIOD == 32'd0) ? 32'd0 : DEFAULT_PERIOD - 32'd1;

  logic [2:0]  state, next_state;
  logic [31:0] plen, plen_d;
  logic        mode_cont, mode_cont_d;
  logic        stop_pending, stop_pending_d;
  logic        accept;

  logic [2:0]  address_q, address_d;
  logic [15:0] writedata_q, writedata_d;
  logic        chipselect_q, chipselect_d;

  assign tmr.address    = address_q;
  assign tmr.writedata  = writedata_q;
  assign tmr.chipselect = chipselect_q;
  assign tmr.write_n    = ~chipselect_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // WR_PL only advances once its write has actually been on the bus, which
  // covers the auto-start case where the FSM resets straight into WR_PL.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_start) next_state = WR_PL;
      WR_PL:   if (chipselect_q) next_state = WR_PH;
      WR_PH:   next_state = WR_CTRL;
      WR_CTRL: next_state = RUN;
      RUN: begin
        if (tmr.irq)        next_state = ACK;
        else if (cmd_stop)  next_state = WR_STOP;
        else if (cmd_start) next_state = WR_PL;
      end
      ACK: begin
        if (stop_pending || cmd_stop) next_state = WR_STOP;
        else if (mode_cont)           next_state = RUN;
        else                          next_state = IDLE;
      end
      WR_STOP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept         = ((state == IDLE) || (state == RUN)) && (next_state == WR_PL);
    plen_d         = plen;
    mode_cont_d    = mode_cont;
    stop_pending_d = stop_pending;
    if (accept) begin
      plen_d      = (cmd_period == 32'd0) ? 32'd0 : cmd_period - 32'd1;
      mode_cont_d = cmd_continuous;
    end
    if (((state == RUN) && tmr.irq && cmd_stop) || ((state == ACK) && cmd_stop)) begin
      stop_pending_d = 1'b1;
    end
    if (state == WR_STOP) begin
      stop_pending_d = 1'b0;
    end

    // Bus outputs are registered, so they are decoded from the upcoming state.
    chipselect_d = 1'b0;
    address_d    = address_q;
    writedata_d  = writedata_q;
    case (next_state)
      WR_PL:   begin chipselect_d = 1'b1; address_d = 3'd2; writedata_d = plen_d[15:0];  end
      WR_PH:   begin chipselect_d = 1'b1; address_d = 3'd3; writedata_d = plen_d[31:16]; end
      WR_CTRL: begin chipselect_d = 1'b1; address_d = 3'd1;
                     writedata_d = {12'h000, 1'b0, 1'b1, mode_cont_d, 1'b1}; end
      ACK:     begin chipselect_d = 1'b1; address_d = 3'd0; writedata_d = 16'h0000; end
      WR_STOP: begin chipselect_d = 1'b1; address_d = 3'd1; writedata_d = 16'h0008; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plen         <= RESET_PLEN;
      mode_cont    <= AUTO_START;
      stop_pending <= 1'b0;
      chipselect_q <= 1'b0;
      address_q    <= 3'd0;
      writedata_q  <= 16'h0000;
      busy         <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
    end else begin
      plen         <= plen_d;
      mode_cont    <= mode_cont_d;
      stop_pending <= stop_pending_d;
      chipselect_q <= chipselect_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      busy         <= (next_state != IDLE);
      tick         <= (state == ACK);
      if (state == ACK) begin
        tick_count <= tick_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios_system_timer_sequencer.sv
// Scoreboard bench: expected bus writes are queued as commands are issued and
// popped as the sequencer writes to the timer.
`default_nettype none

module tb_nios_system_timer_sequencer;
  localparam int TICK_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_start = 1'b0;
  logic              cmd_stop = 1'b0;
  logic [31:0]       cmd_period = 32'd0;
  logic              cmd_continuous = 1'b0;
  logic              irq = 1'b0;
  logic              busy;
  logic              tick;
  logic [TICK_W-1:0] tick_count;

  nios_system_timer_sequencer_if tmr ();
  assign tmr.irq = irq;

  nios_system_timer_sequencer #(.TICK_W(TICK_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_start      (cmd_start),
    .cmd_stop       (cmd_stop),
    .cmd_period     (cmd_period),
    .cmd_continuous (cmd_continuous),
    .tmr            (tmr.master),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int extra_writes = 0;
  int model_count = 0;
  logic [18:0] exp_q[$];
  logic ack_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ack_now;
    logic [18:0] e;
    ack_now = 1'b0;
    if (!reset && tmr.chipselect && !tmr.write_n) begin
      if (exp_q.size() == 0) begin
        extra_writes++;
      end else begin
        e = exp_q.pop_front();
        check_eq("bus_write", {13'd0, tmr.address, tmr.writedata}, {13'd0, e});
      end
      if (tmr.address == 3'd0) ack_now = 1'b1;
    end
    if (!reset && (tick || ack_seen)) begin
      check_eq("tick_pulse", {31'd0, tick}, {31'd0, ack_seen});
      if (ack_seen) check_eq("tick_count", {28'd0, tick_count}, model_count % 16);
    end
    ack_seen = ack_now;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_start(input logic [31:0] p, input bit cont);
    logic [31:0] plen;
    plen = (p == 32'd0) ? 32'd0 : p - 32'd1;
    exp_q.push_back({3'd2, plen[15:0]});
    exp_q.push_back({3'd3, plen[31:16]});
    exp_q.push_back({3'd1, cont ? 16'h0007 : 16'h0005});
  endtask

  task automatic start_cmd(input logic [31:0] p, input bit cont);
    push_start(p, cont);
    cmd_start = 1'b1;
    cmd_period = p;
    cmd_continuous = cont;
    cyc(1);
    cmd_start = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    cyc(4);
  endtask

  task automatic do_ack(input bit with_stop);
    bit found;
    model_count++;
    exp_q.push_back({3'd0, 16'h0000});
    if (with_stop) exp_q.push_back({3'd1, 16'h0008});
    irq = 1'b1;
    cmd_stop = with_stop;
    cyc(1);
    cmd_stop = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (tmr.chipselect && tmr.address == 3'd0) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!found) check_eq("ack_timeout", 32'd0, 32'd1);
    cyc(1);
    irq = 1'b0;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check_eq("rst_cs",    {31'd0, tmr.chipselect}, 32'd0);
    check_eq("rst_wr_n",  {31'd0, tmr.write_n},    32'd1);
    check_eq("rst_addr",  {29'd0, tmr.address},    32'd0);
    check_eq("rst_data",  {16'd0, tmr.writedata},  32'd0);
    check_eq("rst_busy",  {31'd0, busy},           32'd0);
    check_eq("rst_tick",  {31'd0, tick},           32'd0);
    check_eq("rst_count", {28'd0, tick_count},     32'd0);
    reset = 1'b0;
    cyc(2);

    // Continuous start, three acknowledged timeouts.
    start_cmd(32'd50000, 1'b1);
    for (int i = 0; i < 3; i++) do_ack(1'b0);
    check_eq("count_after_3", {28'd0, tick_count}, 32'd3);
    check_eq("busy_run", {31'd0, busy}, 32'd1);

    // Stop together with the irq: ack first, then stop.
    do_ack(1'b1);
    cyc(2);
    check_eq("busy_after_stop_irq", {31'd0, busy}, 32'd0);

    // One-shot finishes in IDLE after its ack.
    start_cmd(32'h0001_0000, 1'b0);
    do_ack(1'b0);
    cyc(1);
    check_eq("busy_after_oneshot", {31'd0, busy}, 32'd0);

    // Restart in RUN with period 1; a start during WR_PH is ignored.
    start_cmd(32'd50000, 1'b1);
    push_start(32'd1, 1'b1);
    cmd_start = 1'b1;
    cmd_period = 32'd1;
    cmd_continuous = 1'b1;
    cyc(1);
    cmd_start = 1'b0;
    cyc(1);
    cmd_start = 1'b1;
    cmd_period = 32'd999;
    cyc(1);
    cmd_start = 1'b0;
    cyc(4);
    check_eq("q_after_restart", exp_q.size(), 32'd0);

    // Start and stop together in RUN: stop wins.
    exp_q.push_back({3'd1, 16'h0008});
    cmd_start = 1'b1;
    cmd_stop = 1'b1;
    cyc(1);
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    cyc(3);
    check_eq("busy_after_stop", {31'd0, busy}, 32'd0);

    // Counter wrap with a 4-bit tick counter.
    start_cmd(32'd100, 1'b1);
    for (int i = 0; i < 17; i++) do_ack(1'b0);
    check_eq("count_wrap", {28'd0, tick_count}, model_count % 16);
    exp_q.push_back({3'd1, 16'h0008});
    cmd_stop = 1'b1;
    cyc(1);
    cmd_stop = 1'b0;
    cyc(3);

    // Reset during WR_PH abandons the sequence.
    exp_q.push_back({3'd2, 16'd9});
    exp_q.push_back({3'd3, 16'd0});
    cmd_start = 1'b1;
    cmd_period = 32'd10;
    cmd_continuous = 1'b1;
    cyc(1);
    cmd_start = 1'b0;
    cyc(1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_cs",   {31'd0, tmr.chipselect}, 32'd0);
    check_eq("midrst_wr_n", {31'd0, tmr.write_n},    32'd1);
    check_eq("midrst_busy", {31'd0, busy},           32'd0);
    exp_q.delete();
    model_count = 0;
    cyc(1);
    check_eq("midrst_cs_next", {31'd0, tmr.chipselect}, 32'd0);
    check_eq("midrst_count",   {28'd0, tick_count},     32'd0);
    reset = 1'b0;
    cyc(5);
    check_eq("busy_post_rst", {31'd0, busy}, 32'd0);

    check_eq("queue_empty", exp_q.size(), 32'd0);
    check_eq("no_extra_writes", extra_writes, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
